msk_col_deserializer: RTL and testbench

- Upstream feeder for the masked state registers of the 32-bit-datapath AES core.
- Accepts shared 32-bit columns one per handshake and packs NCOLS of them into one full shared block.
- Presents the block with a valid/ready handshake to the masked state pipeline.
- Only moves and holds shares: no share is ever XORed, muxed against, or otherwise logically combined with another share.

---
 rtl/msk_col_deserializer.sv | 112 +++++++++++
 tb/tb_msk_col_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/msk_col_deserializer.sv
// Masked column deserializer: packs NCOLS shared W-bit columns into one shared block.
// Latency: out_valid rises the cycle after the last column is accepted; minimum block period NCOLS+1 cycles.
// Backpressure: in_ready is low while a full block waits; the block is held stable until out_ready or flush.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               synchronous abort, drops any partial or full block
//   in_valid/in_ready   column handshake, in_data = shared column (share j of bit i at i*d+j)
//   out_valid/out_ready block handshake, out_data = packed block (column k at [k*W*d +: W*d])
//   col_idx             next column slot to be filled
module msk_col_deserializer #(
  parameter int unsigned d     = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned NCOLS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W*d-1:0]                 in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NCOLS*W*d-1:0]           out_data,
  output logic [$clog2(NCOLS)-1:0]       col_idx
);

  localparam int unsigned CW = $clog2(NCOLS);
  localparam int unsigned CD = W * d;
  localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic            accept;
  logic [NCOLS-1:0] wr_en;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign col_idx   = col_q;

  // flush wins over any handshake, so a column offered alongside it is dropped.
  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (flush) begin
      state_d = FILL;
      col_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            if (col_q == LAST_COL) begin
              col_d   = '0;
              state_d = FULL;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
          col_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // One plain enable-gated register bank per slot. The enable is a pure
  // function of control (slot index and handshake), so shares only ever
  // travel straight from in_data into a flop and from that flop to out_data.
  // flush leaves the banks untouched: every slot is rewritten before the
  // next block can become valid, and skipping the clear avoids extra share
  // transitions.
  for (genvar k = 0; k < NCOLS; k++) begin : g_slot
    logic [CD-1:0] slot_q;

    assign wr_en[k] = accept && (col_q == CW'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (wr_en[k]) begin
        slot_q <= in_data;
      end
    end

    assign out_data[k*CD +: CD] = slot_q;
  end

endmodule

// File: tb/tb_msk_col_deserializer.sv
module tb_msk_col_deserializer;

  localparam int unsigned D  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned CD = W * D;
  localparam int unsigned BW = NC * CD;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CD-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [1:0]    col_idx;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int accs  = 0;

  msk_col_deserializer #(.d(D), .W(W), .NCOLS(NC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .col_idx  (col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so the negedge sees exactly
  // what the next posedge will commit.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) pops++;
    if (rst_n && in_valid && in_ready && !flush) accs++;
  end

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Share 0 is the mask, share 1 is value^mask, interleaved per bit.
  function automatic logic [CD-1:0] share(input logic [W-1:0] v, input logic [W-1:0] m);
    logic [CD-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i*D]     = m[i];
      r[i*D + 1] = v[i] ^ m[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] unshare(input logic [CD-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = s[i*D] ^ s[i*D + 1];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] exp_blk;
  logic [BW-1:0] snap;
  logic [CD-1:0] sc;

  // Sends four back-to-back shared columns and records the expected block.
  task automatic send4(input logic [W-1:0] v0, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic [W-1:0] v3);
    logic [W-1:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int k = 0; k < 4; k++) begin
      sc = share(vals[k], $urandom);
      exp_blk[k*CD +: CD] = sc;
      in_valid = 1'b1;
      in_data  = sc;
      cycle();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  int p0, a0;
  int exp_idx [8] = '{0, 1, 1, 1, 2, 2, 3, 0};
  bit gap_vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] gap_val [7];

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_blk   = '0;

    // ---- reset ----
    cycle(); cycle();
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_col_idx", BW'(col_idx), BW'(0));
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    cycle();
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_out_valid2", BW'(out_valid), BW'(0));

    // ---- four back-to-back columns ----
    send4(32'h11, 32'h22, 32'h33, 32'h44);
    chk("b2b_out_valid", BW'(out_valid), BW'(1));
    chk("b2b_in_ready", BW'(in_ready), BW'(0));
    chk("b2b_col_idx", BW'(col_idx), BW'(0));
    chk("b2b_col0", BW'(unshare(out_data[0*CD +: CD])), BW'(32'h11));
    chk("b2b_col1", BW'(unshare(out_data[1*CD +: CD])), BW'(32'h22));
    chk("b2b_col2", BW'(unshare(out_data[2*CD +: CD])), BW'(32'h33));
    chk("b2b_col3", BW'(unshare(out_data[3*CD +: CD])), BW'(32'h44));
    chk("b2b_block", out_data, exp_blk);

    // ---- backpressure: 10 stalled cycles with junk offered on the input ----
    snap = exp_blk;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      cycle();
      chk("bp_stable", out_data, snap);
      chk("bp_in_ready", BW'(in_ready), BW'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_pop_count", BW'(pops - p0), BW'(1));
    chk("bp_in_ready_after", BW'(in_ready), BW'(1));
    chk("bp_out_valid_after", BW'(out_valid), BW'(0));

    // ---- gapped input ----
    a0 = accs;
    gap_val[0] = 32'hC0DE0001; gap_val[3] = 32'hC0DE0002;
    gap_val[5] = 32'hC0DE0003; gap_val[6] = 32'hC0DE0004;
    for (int i = 0, k = 0; i < 7; i++) begin
      chk($sformatf("gap_col_idx%0d", i), BW'(col_idx), BW'(exp_idx[i]));
      in_valid = gap_vld[i];
      if (gap_vld[i]) begin
        sc = share(gap_val[i], $urandom);
        exp_blk[k*CD +: CD] = sc;
        k++;
        in_data = sc;
      end else begin
        in_data = {$urandom, $urandom};
      end
      cycle();
    end
    in_valid = 1'b0;
    chk("gap_col_idx7", BW'(col_idx), BW'(exp_idx[7]));
    chk("gap_accepts", BW'(accs - a0), BW'(4));
    chk("gap_out_valid", BW'(out_valid), BW'(1));
    chk("gap_block", out_data, exp_blk);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // ---- flush after two columns, flush+in_valid same cycle ----
    in_valid = 1'b1;
    in_data  = share(32'h55, $urandom);
    cycle();
    in_data  = share(32'h66, $urandom);
    cycle();
    chk("fl_col_idx_pre", BW'(col_idx), BW'(2));
    flush    = 1'b1;
    in_data  = share(32'h77, $urandom);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_col_idx", BW'(col_idx), BW'(0));
    chk("fl_out_valid", BW'(out_valid), BW'(0));
    send4(32'hA, 32'hB, 32'hC, 32'hD);
    chk("fl_out_valid_full", BW'(out_valid), BW'(1));
    chk("fl_block", out_data, exp_blk);
    chk("fl_col0", BW'(unshare(out_data[0 +: CD])), BW'(32'hA));
    // flush also discards a waiting full block
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_full_drop", BW'(out_valid), BW'(0));
    chk("fl_full_in_ready", BW'(in_ready), BW'(1));

    // ---- asynchronous reset while full ----
    send4(32'h1111, 32'h2222, 32'h3333, 32'h4444);
    chk("ar_full", BW'(out_valid), BW'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid_now", BW'(out_valid), BW'(0));
    chk("ar_col_idx_now", BW'(col_idx), BW'(0));
    chk("ar_data_clear", out_data, '0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("ar_no_spurious", BW'(out_valid), BW'(0));
    send4(32'h9001, 32'h9002, 32'h9003, 32'h9004);
    chk("ar_out_valid", BW'(out_valid), BW'(1));
    chk("ar_block", out_data, exp_blk);
    chk("ar_col3", BW'(unshare(out_data[3*CD +: CD])), BW'(32'h9004));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
